memory_writeback_unit: RTL and testbench

Final pipeline stage: accepts execute-stage results, performs load/store transactions on the data-memory bus, and produces the register file write port.
- Write-port outputs are destinationEnable, writeAddress, writeData and memoryWritebackValid.
- Handles RV32I sub-word alignment, byte enables, sign/zero extension, misalignment faults and bus timeouts.

---
 rtl/memory_writeback_unit_if.sv | 32 +++
 rtl/memory_writeback_unit.sv | 265 ++++++++++++++++++++++++++
 tb/tb_memory_writeback_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_writeback_unit_if.sv
// Data-memory bus between the writeback unit (master) and the memory (slave).
// A request is held with stable address/data/enables until dataAck; read
// data is valid in the same cycle as dataAck.
interface memory_writeback_unit_if;
   logic        dataRequest;
   logic        dataWrite;
   logic [31:0] dataAddress;
   logic [31:0] dataWriteData;
   logic [3:0]  dataByteEnable;
   logic        dataAck;
   logic [31:0] dataReadData;

   modport master (
      output dataRequest,
      output dataWrite,
      output dataAddress,
      output dataWriteData,
      output dataByteEnable,
      input  dataAck,
      input  dataReadData
   );

   modport slave (
      input  dataRequest,
      input  dataWrite,
      input  dataAddress,
      input  dataWriteData,
      input  dataByteEnable,
      output dataAck,
      output dataReadData
   );
endinterface

// File: rtl/memory_writeback_unit.sv
// Final pipeline stage: takes execute results, runs RV32I loads/stores on the
// data-memory bus and drives the register-file write port.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready for a new execute result; illegal accesses fault here
// MEM_WAIT  | bus request outstanding, waiting for dataAck or timeout
// WRITEBACK | register write slot valid for exactly one cycle
module memory_writeback_unit #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic                    clock,
   input  logic                    reset,

   input  logic                    inValid,
   output logic                    inReady,
   input  logic                    inDestinationEnable,
   input  logic [4:0]              inWriteAddress,
   input  logic [31:0]             inAluResult,
   input  logic [31:0]             inStoreData,
   input  logic                    inLoad,
   input  logic                    inStore,
   input  logic [2:0]              inFunct3,

   memory_writeback_unit_if.master bus,

   output logic                    destinationEnable,
   output logic [4:0]              writeAddress,
   output logic [31:0]             writeData,
   output logic                    memoryWritebackValid,
   output logic                    misalignedFault,
   output logic                    busFault
);

   // Counter only ever needs to reach ACK_TIMEOUT-1 before the timeout fires.
   localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MEM_WAIT  = 2'd1,
      WRITEBACK = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [CW-1:0] count_q, count_d;

   logic         lat_load_q, lat_load_d;
   logic [2:0]   lat_funct3_q, lat_funct3_d;
   logic [1:0]   lat_lane_q, lat_lane_d;
   logic [4:0]   lat_rd_q, lat_rd_d;
   logic         lat_rd_en_q, lat_rd_en_d;

   logic         req_q, req_d;
   logic         write_q, write_d;
   logic [31:0]  addr_q, addr_d;
   logic [31:0]  wdata_q, wdata_d;
   logic [3:0]   be_q, be_d;

   logic         dest_en_q, dest_en_d;
   logic [4:0]   waddr_q, waddr_d;
   logic [31:0]  rf_data_q, rf_data_d;
   logic         valid_q, valid_d;
   logic         mis_q, mis_d;
   logic         bus_fault_q, bus_fault_d;

   logic         accept;
   logic         access_ok;
   logic [31:0]  store_lanes;
   logic [3:0]   store_be;
   logic [31:0]  read_shifted;
   logic [31:0]  load_value;

   assign inReady = (state_q == IDLE);
   assign accept  = inValid && inReady;

   // Legality and alignment of the incoming load/store.
   always_comb begin
      access_ok = 1'b0;
      if (inLoad && !inStore) begin
         unique case (inFunct3)
            3'b000, 3'b100: access_ok = 1'b1;
            3'b001, 3'b101: access_ok = !inAluResult[0];
            3'b010:         access_ok = (inAluResult[1:0] == 2'b00);
            default:        access_ok = 1'b0;
         endcase
      end else if (inStore && !inLoad) begin
         unique case (inFunct3)
            3'b000:  access_ok = 1'b1;
            3'b001:  access_ok = !inAluResult[0];
            3'b010:  access_ok = (inAluResult[1:0] == 2'b00);
            default: access_ok = 1'b0;
         endcase
      end
   end

   // Store data replicated across lanes, with enables for the addressed bytes.
   always_comb begin
      store_lanes = inStoreData;
      store_be    = 4'b1111;
      unique case (inFunct3[1:0])
         2'b00: begin
            store_lanes = {4{inStoreData[7:0]}};
            store_be    = 4'b0001 << inAluResult[1:0];
         end
         2'b01: begin
            store_lanes = {2{inStoreData[15:0]}};
            store_be    = 4'b0011 << inAluResult[1:0];
         end
         default: begin
            store_lanes = inStoreData;
            store_be    = 4'b1111;
         end
      endcase
   end

   // Load lane selection followed by sign or zero extension.
   always_comb begin
      read_shifted = bus.dataReadData >> {lat_lane_q, 3'b000};
      unique case (lat_funct3_q)
         3'b000:  load_value = {{24{read_shifted[7]}}, read_shifted[7:0]};
         3'b001:  load_value = {{16{read_shifted[15]}}, read_shifted[15:0]};
         3'b100:  load_value = {24'd0, read_shifted[7:0]};
         3'b101:  load_value = {16'd0, read_shifted[15:0]};
         default: load_value = bus.dataReadData;
      endcase
   end

   // Next-state and next-output decisions for the sequencing FSM.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      lat_load_d   = lat_load_q;
      lat_funct3_d = lat_funct3_q;
      lat_lane_d   = lat_lane_q;
      lat_rd_d     = lat_rd_q;
      lat_rd_en_d  = lat_rd_en_q;
      req_d        = req_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      waddr_d      = waddr_q;
      rf_data_d    = rf_data_q;
      dest_en_d    = 1'b0;
      valid_d      = 1'b0;
      mis_d        = 1'b0;
      bus_fault_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               lat_load_d   = inLoad;
               lat_funct3_d = inFunct3;
               lat_lane_d   = inAluResult[1:0];
               lat_rd_d     = inWriteAddress;
               lat_rd_en_d  = inDestinationEnable;
               if (!inLoad && !inStore) begin
                  state_d   = WRITEBACK;
                  valid_d   = 1'b1;
                  dest_en_d = inDestinationEnable && (inWriteAddress != 5'd0);
                  waddr_d   = inWriteAddress;
                  rf_data_d = inAluResult;
               end else if (!access_ok) begin
                  mis_d = 1'b1;
               end else begin
                  state_d = MEM_WAIT;
                  count_d = '0;
                  req_d   = 1'b1;
                  write_d = inStore;
                  addr_d  = {inAluResult[31:2], 2'b00};
                  be_d    = inStore ? store_be : 4'b1111;
                  wdata_d = inStore ? store_lanes : 32'd0;
               end
            end
         end
         MEM_WAIT: begin
            if (bus.dataAck) begin
               req_d   = 1'b0;
               count_d = '0;
               if (lat_load_q) begin
                  state_d   = WRITEBACK;
                  valid_d   = 1'b1;
                  dest_en_d = lat_rd_en_q && (lat_rd_q != 5'd0);
                  waddr_d   = lat_rd_q;
                  rf_data_d = load_value;
               end else begin
                  state_d = IDLE;
               end
            end else if ((ACK_TIMEOUT != 0) && (count_q == TMO_LAST)) begin
               req_d       = 1'b0;
               count_d     = '0;
               bus_fault_d = 1'b1;
               state_d     = IDLE;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         WRITEBACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State, latched transaction and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         count_q      <= '0;
         lat_load_q   <= 1'b0;
         lat_funct3_q <= 3'd0;
         lat_lane_q   <= 2'd0;
         lat_rd_q     <= 5'd0;
         lat_rd_en_q  <= 1'b0;
         req_q        <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         be_q         <= 4'd0;
         dest_en_q    <= 1'b0;
         waddr_q      <= 5'd0;
         rf_data_q    <= 32'd0;
         valid_q      <= 1'b0;
         mis_q        <= 1'b0;
         bus_fault_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         lat_load_q   <= lat_load_d;
         lat_funct3_q <= lat_funct3_d;
         lat_lane_q   <= lat_lane_d;
         lat_rd_q     <= lat_rd_d;
         lat_rd_en_q  <= lat_rd_en_d;
         req_q        <= req_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         dest_en_q    <= dest_en_d;
         waddr_q      <= waddr_d;
         rf_data_q    <= rf_data_d;
         valid_q      <= valid_d;
         mis_q        <= mis_d;
         bus_fault_q  <= bus_fault_d;
      end
   end

   assign bus.dataRequest    = req_q;
   assign bus.dataWrite      = write_q;
   assign bus.dataAddress    = addr_q;
   assign bus.dataWriteData  = wdata_q;
   assign bus.dataByteEnable = be_q;

   assign destinationEnable    = dest_en_q;
   assign writeAddress         = waddr_q;
   assign writeData            = rf_data_q;
   assign memoryWritebackValid = valid_q;
   assign misalignedFault      = mis_q;
   assign busFault             = bus_fault_q;

endmodule

// File: tb/tb_memory_writeback_unit.sv
// Randomized bench for memory_writeback_unit against a transaction-level model.
module tb_memory_writeback_unit;
   localparam int unsigned TMO = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        inValid = 1'b0;
   logic        inReady;
   logic        inDestinationEnable = 1'b0;
   logic [4:0]  inWriteAddress = 5'd0;
   logic [31:0] inAluResult = 32'd0;
   logic [31:0] inStoreData = 32'd0;
   logic        inLoad = 1'b0;
   logic        inStore = 1'b0;
   logic [2:0]  inFunct3 = 3'd0;
   logic        destinationEnable;
   logic [4:0]  writeAddress;
   logic [31:0] writeData;
   logic        memoryWritebackValid;
   logic        misalignedFault;
   logic        busFault;

   memory_writeback_unit_if bus ();

   memory_writeback_unit #(.ACK_TIMEOUT(TMO)) dut (
      .clock               (clock),
      .reset               (reset),
      .inValid             (inValid),
      .inReady             (inReady),
      .inDestinationEnable (inDestinationEnable),
      .inWriteAddress      (inWriteAddress),
      .inAluResult         (inAluResult),
      .inStoreData         (inStoreData),
      .inLoad              (inLoad),
      .inStore             (inStore),
      .inFunct3            (inFunct3),
      .bus                 (bus),
      .destinationEnable   (destinationEnable),
      .writeAddress        (writeAddress),
      .writeData           (writeData),
      .memoryWritebackValid(memoryWritebackValid),
      .misalignedFault     (misalignedFault),
      .busFault            (busFault)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] hold_wdata = 32'd0;
   logic [4:0]  hold_waddr = 5'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Access size in bytes, 0 when the access can never be legal.
   function automatic int access_size(input bit ld, input bit st, input logic [2:0] f3);
      if (ld && st) return 0;
      if (ld && (f3 == 3'd0 || f3 == 3'd4)) return 1;
      if (ld && (f3 == 3'd1 || f3 == 3'd5)) return 2;
      if (ld && f3 == 3'd2) return 4;
      if (st && f3 == 3'd0) return 1;
      if (st && f3 == 3'd1) return 2;
      if (st && f3 == 3'd2) return 4;
      return 0;
   endfunction

   function automatic logic [31:0] load_model(input logic [2:0] f3, input int lane,
                                              input logic [31:0] rdata);
      logic [31:0] w;
      logic [31:0] b;
      logic [31:0] h;
      w = rdata / (32'd1 << (8 * lane));
      b = w % 256;
      h = w % 65536;
      case (f3)
         3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return rdata;
      endcase
   endfunction

   // One transaction from accept to return to IDLE. ackdly = number of
   // MEM_WAIT cycles before the ack cycle; TMO or more means no ack at all.
   task automatic run_txn(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] rd, input bit rden, input int ackdly,
                          input logic [31:0] rdata);
      int          size;
      int          lane;
      bit          acked;
      logic [31:0] exp_be;
      logic [31:0] exp_wd;
      logic [31:0] exp_ld;
      chk("ready_before", inReady, 1);
      inValid = 1'b1; inLoad = ld; inStore = st; inFunct3 = f3;
      inAluResult = addr; inStoreData = sdata; inWriteAddress = rd;
      inDestinationEnable = rden;
      step();
      inValid = 1'b0; inLoad = 1'($urandom); inStore = 1'($urandom);
      inFunct3 = 3'($urandom); inAluResult = $urandom; inStoreData = $urandom;
      inWriteAddress = 5'($urandom); inDestinationEnable = 1'($urandom);

      size = access_size(ld, st, f3);
      lane = int'(addr % 4);
      if (!ld && !st) begin
         chk("alu_valid", memoryWritebackValid, 1);
         chk("alu_den", destinationEnable, (rden && rd != 5'd0) ? 1 : 0);
         chk("alu_waddr", writeAddress, rd);
         chk("alu_wdata", writeData, addr);
         chk("alu_ready", inReady, 0);
         chk("alu_req", bus.dataRequest, 0);
         hold_wdata = addr; hold_waddr = rd;
         step();
         chk("alu_valid_off", memoryWritebackValid, 0);
         chk("alu_den_off", destinationEnable, 0);
         chk("alu_ready_after", inReady, 1);
      end else if (size == 0 || (addr % size) != 0) begin
         chk("mis_pulse", misalignedFault, 1);
         chk("mis_req", bus.dataRequest, 0);
         chk("mis_valid", memoryWritebackValid, 0);
         chk("mis_ready", inReady, 1);
         step();
         chk("mis_pulse_end", misalignedFault, 0);
         chk("mis_req_after", bus.dataRequest, 0);
      end else begin
         exp_be = st ? (((32'd1 << size) - 1) << lane) % 16 : 32'hF;
         exp_wd = (size == 1) ? (sdata % 256) * 32'h01010101 :
                  (size == 2) ? (sdata % 65536) * 32'h00010001 : sdata;
         acked = 1'b0;
         for (int i = 0; i < int'(TMO); i++) begin
            if (!acked) begin
               chk("wait_req", bus.dataRequest, 1);
               chk("wait_write", bus.dataWrite, st);
               chk("wait_addr", bus.dataAddress, addr - lane);
               chk("wait_be", bus.dataByteEnable, exp_be);
               if (st) chk("wait_wdata", bus.dataWriteData, exp_wd);
               chk("wait_valid", memoryWritebackValid, 0);
               chk("wait_busfault", busFault, 0);
               if (i == ackdly) begin
                  bus.dataAck = 1'b1;
                  bus.dataReadData = rdata;
               end
               step();
               bus.dataAck = 1'b0;
               bus.dataReadData = $urandom;
               if (i == ackdly) acked = 1'b1;
            end
         end
         if (acked && ld) begin
            exp_ld = load_model(f3, lane, rdata);
            chk("ld_valid", memoryWritebackValid, 1);
            chk("ld_data", writeData, exp_ld);
            chk("ld_waddr", writeAddress, rd);
            chk("ld_den", destinationEnable, (rden && rd != 5'd0) ? 1 : 0);
            chk("ld_req_off", bus.dataRequest, 0);
            hold_wdata = exp_ld; hold_waddr = rd;
            step();
            chk("ld_valid_off", memoryWritebackValid, 0);
            chk("ld_ready_after", inReady, 1);
         end else if (acked) begin
            chk("st_req_off", bus.dataRequest, 0);
            chk("st_no_wb", memoryWritebackValid, 0);
            chk("st_ready_after", inReady, 1);
         end else begin
            chk("tmo_busfault", busFault, 1);
            chk("tmo_req_off", bus.dataRequest, 0);
            chk("tmo_ready", inReady, 1);
            chk("tmo_no_wb", memoryWritebackValid, 0);
            step();
            chk("tmo_pulse_end", busFault, 0);
         end
      end
      chk("hold_wdata", writeData, hold_wdata);
      chk("hold_waddr", writeAddress, hold_waddr);
   endtask

   initial begin
      bus.dataAck = 1'b0;
      bus.dataReadData = 32'd0;
      reset = 1'b1;
      step(); step();
      chk("rst_ready", inReady, 1);
      chk("rst_req", bus.dataRequest, 0);
      chk("rst_addr", bus.dataAddress, 0);
      chk("rst_be", bus.dataByteEnable, 0);
      chk("rst_valid", memoryWritebackValid, 0);
      chk("rst_den", destinationEnable, 0);
      chk("rst_wdata", writeData, 0);
      chk("rst_waddr", writeAddress, 0);
      chk("rst_faults", {misalignedFault, busFault}, 0);
      reset = 1'b0;
      step();

      run_txn(0, 0, 3'd0, 32'h12345678, 32'd0, 5'd5, 1, 0, 32'd0);
      run_txn(1, 0, 3'd0, 32'h00001003, 32'd0, 5'd7, 1, 2, 32'h80FF00AA);
      chk("lb_const", writeData, 32'hFFFFFF80);
      run_txn(1, 0, 3'd4, 32'h00001003, 32'd0, 5'd7, 1, 2, 32'h80FF00AA);
      chk("lbu_const", writeData, 32'h00000080);
      run_txn(0, 1, 3'd1, 32'h00002002, 32'hDEADBEEF, 5'd3, 0, 1, 32'd0);
      run_txn(1, 0, 3'd2, 32'h00003001, 32'd0, 5'd9, 1, 0, 32'd0);
      run_txn(1, 0, 3'd2, 32'h00004000, 32'd0, 5'd10, 1, 99, 32'd0);
      run_txn(1, 0, 3'd2, 32'h00005008, 32'd0, 5'd0, 1, 0, 32'hCAFEF00D);
      run_txn(1, 1, 3'd0, 32'h00006000, 32'd0, 5'd4, 1, 0, 32'd0);

      // Reset during MEM_WAIT, then a stray ack while idle.
      inValid = 1'b1; inLoad = 1'b1; inStore = 1'b0; inFunct3 = 3'd2;
      inAluResult = 32'h00007000; inWriteAddress = 5'd12; inDestinationEnable = 1'b1;
      step();
      inValid = 1'b0;
      chk("rmid_req", bus.dataRequest, 1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rmid_req_off", bus.dataRequest, 0);
      chk("rmid_ready", inReady, 1);
      chk("rmid_addr", bus.dataAddress, 0);
      chk("rmid_wdata", writeData, 0);
      chk("rmid_busfault", busFault, 0);
      hold_wdata = 32'd0; hold_waddr = 5'd0;
      bus.dataAck = 1'b1; bus.dataReadData = 32'h55AA55AA;
      step();
      bus.dataAck = 1'b0;
      chk("stray_valid", memoryWritebackValid, 0);
      chk("stray_req", bus.dataRequest, 0);
      chk("stray_ready", inReady, 1);
      chk("stray_wdata", writeData, 0);
      step();
      chk("stray_valid2", memoryWritebackValid, 0);

      for (int n = 0; n < 300; n++) begin
         int          kind;
         bit          ld;
         bit          st;
         logic [31:0] addr;
         kind = int'($urandom_range(0, 7));
         ld = (kind >= 2 && kind <= 4) || kind == 7;
         st = (kind == 5 || kind == 6) || kind == 7;
         addr = $urandom;
         if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
         run_txn(ld, st, 3'($urandom), addr, $urandom,
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                 1'($urandom), int'($urandom_range(0, 5)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
